// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the read-side FIFO packer: FSM encoding, default sizes
// and the lane-counter width helper.
package fifo_rd_packer_pkg;

  localparam int unsigned DSIZE_DEF = 6;
  localparam int unsigned PACK_DEF  = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    EMIT = 2'd2
  } rd_state_e;

  // Lane counter must represent 0..PACK inclusive.
  function automatic int unsigned cnt_width(input int unsigned pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Valid/ready output holding register: loads when told to, holds while the
// consumer stalls, drops valid once the word has been taken.
module fifo_out_reg #(
  parameter int unsigned W = 24
) (
  input  logic         rclk,
  input  logic         rrst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic [W-1:0] out_payload,
  output logic         out_valid,
  output logic         free_c
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_payload = data_q;
  assign out_valid   = valid_q;
  // Free when empty, or when the current word is being taken this cycle.
  assign free_c      = !valid_q || out_ready;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops DSIZE-bit words and packs PACK of them into one
// valid/ready output word. Optional partial-word flush under RD_PACKER_FLUSH_EN.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter  int unsigned DSIZE = DSIZE_DEF,
  parameter  int unsigned PACK  = PACK_DEF,
  localparam int unsigned CW    = cnt_width(PACK)
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef RD_PACKER_FLUSH_EN
  ,
  input  logic                  flush,
  output logic [CW-1:0]         out_cnt
`endif
);

  localparam int unsigned DW = DSIZE * PACK;
`ifdef RD_PACKER_FLUSH_EN
  localparam int unsigned OW = DW + CW;
`else
  localparam int unsigned OW = DW;
`endif

  rd_state_e                  state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       inflight_q, inflight_d;
  logic [PACK-1:0][DSIZE-1:0] acc_q, acc_d;
  logic                       run_q;

  logic [CW:0]                sum_c;
  logic                       free_c;
  logic                       load_c;
  logic                       last_cap_c;
  logic                       part_go_c;
  logic                       flush_hold_c;
  logic [OW-1:0]              load_data_c;
  logic [OW-1:0]              out_payload;

  // Occupied plus requested lanes, one bit wider so PACK is representable.
  assign sum_c = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

  // run_q gives a synchronous release: no pop until the first edge after reset.
  assign rinc = run_q && !rempty && (state_q == FILL) &&
                (sum_c < (CW+1)'(PACK)) && !flush_hold_c;

  assign last_cap_c = inflight_q && (cnt_q == CW'(PACK - 1));
  assign part_go_c  = flush_hold_c && !inflight_q && (cnt_q != '0);

`ifdef RD_PACKER_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
  logic flush_act_c;

  // A flush is remembered until the partial word has been emitted, so a
  // single-cycle request survives an in-flight pop.
  assign flush_act_c  = flush && (state_q == FILL) && ((cnt_q != '0) || inflight_q);
  assign flush_hold_c = flush_act_c || flush_pend_q;

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (state_q == EMIT) begin
      flush_pend_d = 1'b0;
    end else if (flush_act_c) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end

  assign load_data_c = {cnt_q, acc_q};
`else
  assign flush_hold_c = 1'b0;
  assign load_data_c  = acc_q;
`endif

  // FSM state register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (last_cap_c || part_go_c) begin
          state_d = free_c ? EMIT : HOLD;
        end
      end
      HOLD: begin
        if (free_c) begin
          state_d = EMIT;
        end
      end
      EMIT:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM outputs: EMIT is only reached when the output register is free.
  always_comb begin
    load_c = 1'b0;
    if (state_q == EMIT) begin
      load_c = 1'b1;
    end
  end

  // Lane capture; clearing on emit leaves unused lanes of a partial word zero.
  always_comb begin
    inflight_d = rinc;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    if (inflight_q) begin
      for (int i = 0; i < int'(PACK); i++) begin
        if (cnt_q == CW'(i)) begin
          acc_d[i] = rdata;
        end
      end
      cnt_d = cnt_q + CW'(1);
    end
    if (load_c) begin
      cnt_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      acc_q      <= '0;
      run_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      acc_q      <= acc_d;
      run_q      <= 1'b1;
    end
  end

  fifo_out_reg #(
    .W (OW)
  ) u_out_reg (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .load        (load_c),
    .load_data   (load_data_c),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .free_c      (free_c)
  );

  assign out_data = out_payload[DW-1:0];
`ifdef RD_PACKER_FLUSH_EN
  assign out_cnt  = out_payload[OW-1:DW];
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized bench for fifo_rd_packer: a queue-based FIFO feeds the DUT and a
// word-stream model predicts every packed output. Honors RD_PACKER_FLUSH_EN.
module tb_fifo_rd_packer;
  import fifo_rd_packer_pkg::*;

  localparam int unsigned DSIZE = 6;
  localparam int unsigned PACK  = 4;
  localparam int unsigned DW    = DSIZE * PACK;
  localparam int unsigned CW    = 3;

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             rempty = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             rinc;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
`ifdef RD_PACKER_FLUSH_EN
  logic             flush = 1'b0;
  logic [CW-1:0]    out_cnt;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RD_PACKER_FLUSH_EN
    ,
    .flush     (flush),
    .out_cnt   (out_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   c;
  } exp_t;

  exp_t             exp_q[$];
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] part_q[$];
  logic [DSIZE-1:0] words[$];

  int total = 0;
  int bad   = 0;
  int n_pop = 0, n_out = 0, n_vcyc = 0;
  int p0, o0, v0;

  logic [DW-1:0]    last_out = '0;
  int unsigned      last_cnt = 0;
  bit               rd_pend = 0;
  logic [DSIZE-1:0] rd_word = '0;
  bit               hold_prev = 0;
  logic [DW-1:0]    hold_data = '0;

  int          empty_mode = 0;  // 0: only when FIFO empty, 1: toggle, 2: random
  bit          ready_rand = 0;
  bit          ready_val  = 0;
  bit          flush_req  = 0;
  int unsigned flush_pct  = 0;
  bit          tgl = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack_words(input logic [DSIZE-1:0] w[$]);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < w.size(); i++) r = r | (DW'(w[i]) << (i * DSIZE));
    return r;
  endfunction

  function automatic void push_exp(input int unsigned c);
    exp_t e;
    e.d = pack_words(part_q);
    e.c = c;
    exp_q.push_back(e);
    part_q.delete();
  endfunction

  // One cycle: drive at negedge, observe 1 time unit later, update model.
  task automatic step();
    bit   gate;
    exp_t e;
    @(negedge rclk);
    if (rd_pend) begin
      rdata   = rd_word;
      rd_pend = 0;
    end
    gate = 0;
    if (empty_mode == 1) begin
      tgl  = ~tgl;
      gate = tgl;
    end else if (empty_mode == 2) begin
      gate = ($urandom_range(0, 2) == 0);
    end
    rempty    = (fifo_q.size() == 0) || gate;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
`ifdef RD_PACKER_FLUSH_EN
    flush     = flush_req || (flush_pct != 0 && $urandom_range(0, 99) < flush_pct);
    flush_req = 0;
`endif
    #1;
    if (rinc) check("pop_while_empty", rempty, 0);
    if (hold_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hold_data);
    end
    if (out_valid) n_vcyc++;
    if (out_valid && out_ready) begin
      last_out = out_data;
      n_out++;
`ifdef RD_PACKER_FLUSH_EN
      last_cnt = out_cnt;
`endif
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_data, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.d);
`ifdef RD_PACKER_FLUSH_EN
        check("out_cnt", out_cnt, e.c);
`endif
      end
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
`ifdef RD_PACKER_FLUSH_EN
    if (flush && part_q.size() != 0) push_exp(part_q.size());
`endif
    if (rinc && fifo_q.size() != 0) begin
      rd_word = fifo_q.pop_front();
      rd_pend = 1;
      part_q.push_back(rd_word);
      n_pop++;
      if (part_q.size() == PACK) push_exp(PACK);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic push_rand(input int n);
    for (int k = 0; k < n; k++) fifo_q.push_back(DSIZE'($urandom));
  endtask

  // Reset clears outputs, discards any partial word and any in-flight pop.
  task automatic reset_dut();
    rempty = (fifo_q.size() == 0);
    rrst_n = 1'b0;
    #1;
    exp_q.delete();
    part_q.delete();
    rd_pend   = 0;
    hold_prev = 0;
    repeat (2) @(posedge rclk);
    #1;
    check("rst_rinc", rinc, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    check("rinc_before_edge", rinc, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // Reset with data available; first pop only after the first edge.
    ready_val = 1;
    push_rand(4);
    reset_dut();
    step();
    check("rinc_first_edge", rinc, 1);
    run(12);

    // Known packet: lane0=01, lane1=02<<6, lane2=03<<12, lane3=04<<18.
    fifo_q.push_back(6'h01);
    fifo_q.push_back(6'h02);
    fifo_q.push_back(6'h03);
    fifo_q.push_back(6'h04);
    reset_dut();
    o0 = n_out;
    v0 = n_vcyc;
    run(14);
    check("pack_1234", last_out, 24'h103081);
    check("one_output", n_out - o0, 1);
    check("valid_one_cycle", n_vcyc - v0, 1);

    // Backpressure: two packets, first held, second stuck in HOLD.
    ready_val = 0;
    push_rand(8);
    reset_dut();
    p0 = n_pop;
    run(30);
    check("pops_8", n_pop - p0, 8);
    check("exp_pending", exp_q.size(), 2);
    check("held_valid", out_valid, 1);
    if (exp_q.size() != 0) check("held_first", out_data, exp_q[0].d);
    check("hold_state", 64'(dut.state_q), 64'(HOLD));
    check("rinc_in_hold", rinc, 0);
    ready_val = 1;
    o0 = n_out;
    run(3);
    check("release_word2", n_out - o0, 2);

    // rempty toggling every cycle, random backpressure.
    ready_rand = 1;
    empty_mode = 1;
    push_rand(40);
    p0 = n_pop;
    o0 = n_out;
    run(300);
    check("toggle_pops", n_pop - p0, 40);
    check("toggle_outs", n_out - o0, 10);

    // Fully random traffic.
    empty_mode = 2;
`ifdef RD_PACKER_FLUSH_EN
    flush_pct = 5;
`endif
    for (int r = 0; r < 6; r++) begin
      push_rand($urandom_range(5, 25));
      run($urandom_range(20, 80));
    end
    flush_pct  = 0;
    empty_mode = 0;
    ready_rand = 0;
    ready_val  = 1;
    for (int k = 0; k < 2000 && fifo_q.size() != 0; k++) step();
    check("drain_fifo", fifo_q.size(), 0);
    run(20);
    check("drain_outputs", exp_q.size(), 0);

    // Async reset with a held output and cnt=2 in the accumulator.
    reset_dut();
    ready_val = 0;
    push_rand(6);
    run(20);
    check("pre_reset_valid", out_valid, 1);
    @(posedge rclk);
    #2;
    rrst_n = 1'b0;
    #1;
    check("async_clr_valid", out_valid, 0);
    check("async_clr_data", out_data, 0);
    check("async_clr_rinc", rinc, 0);
    reset_dut();
    ready_val = 1;
    words.delete();
    words.push_back(6'h11);
    words.push_back(6'h22);
    words.push_back(6'h33);
    words.push_back(6'h05);
    for (int k = 0; k < 4; k++) fifo_q.push_back(words[k]);
    o0 = n_out;
    run(14);
    check("post_reset_word", last_out, pack_words(words));
    check("post_reset_count", n_out - o0, 1);

`ifdef RD_PACKER_FLUSH_EN
    // Partial word via flush.
    reset_dut();
    fifo_q.push_back(6'h3F);
    fifo_q.push_back(6'h01);
    run(6);
    flush_req = 1;
    o0 = n_out;
    run(10);
    check("flush_word", last_out, 24'h00007F);
    check("flush_cnt", last_cnt, 2);
    check("flush_count", n_out - o0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
